hex_msg_scheduler: RTL and testbench
====================================

Name: hex_msg_scheduler

Overview:
- Owns the four-digit seven-segment bank (HEX3..HEX0) and decides each cycle whether it shows a numeric BCD value or a timed, blinking text message ("EASY", "HARD", "DEAD").
- Numeric producers (score or timer) write continuously. Message producers use a req/ack handshake.
- Sits between game logic and the board HEX pins. All glyph decoding is internal.

Parameters:
- TICK_CYCLES, 50_000_000: clk cycles per display tick (1 s at 50 MHz).
- MSG_ON_TICKS, 2: ticks a message stays lit per blink.
- MSG_OFF_TICKS, 1: ticks a message stays blank between blinks.
- MSG_BLINKS, 3: number of lit phases per message (at least 1).
- LZ_BLANK, 1: 1 = blank leading zeros of the numeric value; HEX0 is never blanked.

Ports:
- clk, input, 1: system clock.
- rst_n, input, 1: synchronous, active-low reset.
- value_bcd, input, 16: four BCD digits, [15:12] maps to HEX3 and [3:0] maps to HEX0.
- value_valid, input, 1: capture value_bcd this cycle.
- msg_req, input, 1: message request. Level signal; hold it until msg_ack.
- msg_id, input, 2: selects the message. 0 = EASY, 1 = HARD, 2 = DEAD, 3 = all blank.
- msg_ack, output, 1: one-cycle pulse when the request is accepted.
- busy, output, 1: high while a message sequence is running.
- hex3, hex2, hex1, hex0, output, 7 each: segment drive, active-low, bit order {g,f,e,d,c,b,a}.

Behaviour:
- Reset (rst_n low at a clk edge):
  - state = S_VALUE; latched value = 16'h0000; tick counter, phase counter and blink counter all 0.
  - msg_ack = 0; busy = 0; hex3..hex0 = 7'b1111111.
  - Reset mid-message aborts the message immediately. No ack is pending after reset.
- Value capture:
  - If value_valid = 1, value_bcd is latched at the clk edge. The latch updates in every state.
  - A value written during a message is what appears when the message ends.
- Output timing: hex outputs are registered. They reflect state and latched data exactly one cycle after a change.
- S_VALUE:
  - Shows the latched digits.
  - Any digit greater than 9 shows blank (7'b1111111).
  - With LZ_BLANK = 1, leading zero digits among HEX3..HEX1 are blanked; HEX0 is never blanked.
- Accepting a request:
  - Happens in S_VALUE when msg_req = 1.
  - On that edge: latch msg_id, pulse msg_ack = 1 for that cycle, set busy = 1, clear the tick and phase counters, set blink count = 1, go to S_MSG_ON.
- Requests while busy:
  - msg_req in S_MSG_ON or S_MSG_OFF is not acknowledged and not queued.
  - The requester keeps holding; it is accepted in the first S_VALUE cycle.
- Tick generation:
  - Free-running counter 0..TICK_CYCLES-1. It is cleared on request acceptance so the first phase is exactly full length.
  - tick = 1 when the counter reaches TICK_CYCLES-1.
- S_MSG_ON:
  - Displays the message glyphs.
  - After MSG_ON_TICKS ticks: if blink count = MSG_BLINKS, go to S_VALUE and clear busy; otherwise go to S_MSG_OFF.
- S_MSG_OFF:
  - All digits blank.
  - After MSG_OFF_TICKS ticks: increment blink count, go to S_MSG_ON.
- Sequence length: MSG_BLINKS×MSG_ON_TICKS + (MSG_BLINKS−1)×MSG_OFF_TICKS ticks.
- Back-to-back messages: busy falls in the same cycle S_VALUE is entered. A held msg_req is acked on the next edge, so the numeric value is visible for exactly 1 cycle.
- msg_id is sampled only at acceptance. Later changes have no effect on the running message.
- Counter widths: derived with $clog2. No counter may wrap before its terminal compare.

Decomposition:
- Package hex_disp_pkg holds:
  - glyph code typedef, 5 bits: 0–9 are digits; then E, A, S, Y, H, R, D; then BLANK.
  - message id constants MSG_EASY, MSG_HARD, MSG_DEAD, MSG_BLANK.
  - FSM state enum S_VALUE, S_MSG_ON, S_MSG_OFF.
  - a constant function mapping msg_id to four glyph codes.
- One sub-module, glyph_to_seg: purely combinational, 5-bit glyph in, 7-bit active-low segments out, unknown codes blank.
- Instantiated four times ahead of the output registers.

Test Plan (TICK_CYCLES=4, MSG_ON_TICKS=2, MSG_OFF_TICKS=1, MSG_BLINKS=2, LZ_BLANK=1):
- Reset:
  - Stimulus: hold rst_n low for 3 cycles, then release.
  - Response: hex all 7'h7F during reset. One cycle after release: hex0 = 7'b1000000, hex3..hex1 = 7'h7F, busy = 0, msg_ack = 0.
- Value display:
  - Stimulus: value_bcd = 16'h0407 with value_valid for 1 cycle; then 16'h12F9.
  - Response for 16'h0407: hex3 blank, hex2 = 4 (0011001), hex1 = 0 (1000000), hex0 = 7 (1111000).
  - Response for 16'h12F9: hex1 blank because digit F is invalid, hex0 = 9 (0010000).
- Message sequence:
  - Stimulus: msg_req = 1, msg_id = 1 (HARD).
  - Response: msg_ack is high for exactly 1 cycle, then H A R D is shown for 8 cycles, blank for 4, HARD for 8, then the value returns.
  - busy is high for exactly 20 cycles.
- Busy rejection:
  - Stimulus: msg_req for EASY asserted 3 cycles into HARD and held.
  - Response: no ack during HARD. Ack arrives on the first cycle after busy falls. The value is shown for 1 cycle, then EASY runs.
- Value update mid-message:
  - Stimulus: value_valid with 16'h0099 during S_MSG_OFF.
  - Response: the digits stay blank until the message ends, then 99 is shown with hex3 and hex2 blank.
- Reset mid-message:
  - Stimulus: rst_n low for 1 cycle during S_MSG_ON.
  - Response: next cycle hex = all 7'h7F, busy = 0, state S_VALUE. The following cycle shows 0.

Source files
------------

// File: rtl/hex_disp_pkg.sv
// Shared types and constants for the seven-segment message scheduler.
package hex_disp_pkg;

    localparam int unsigned GLYPH_W = 5;
    localparam int unsigned SEG_W   = 7;
    localparam int unsigned DIGITS  = 4;

    typedef logic [GLYPH_W-1:0] glyph_t;

    // Digit glyphs share their numeric value; letters follow, then blank.
    localparam glyph_t G_0     = 5'd0;
    localparam glyph_t G_1     = 5'd1;
    localparam glyph_t G_2     = 5'd2;
    localparam glyph_t G_3     = 5'd3;
    localparam glyph_t G_4     = 5'd4;
    localparam glyph_t G_5     = 5'd5;
    localparam glyph_t G_6     = 5'd6;
    localparam glyph_t G_7     = 5'd7;
    localparam glyph_t G_8     = 5'd8;
    localparam glyph_t G_9     = 5'd9;
    localparam glyph_t G_E     = 5'd10;
    localparam glyph_t G_A     = 5'd11;
    localparam glyph_t G_S     = 5'd12;
    localparam glyph_t G_Y     = 5'd13;
    localparam glyph_t G_H     = 5'd14;
    localparam glyph_t G_R     = 5'd15;
    localparam glyph_t G_D     = 5'd16;
    localparam glyph_t G_BLANK = 5'd17;

    localparam logic [SEG_W-1:0] SEG_BLANK = 7'b1111111;

    localparam logic [1:0] MSG_EASY  = 2'd0;
    localparam logic [1:0] MSG_HARD  = 2'd1;
    localparam logic [1:0] MSG_DEAD  = 2'd2;
    localparam logic [1:0] MSG_BLANK = 2'd3;

    typedef enum logic [1:0] {
        S_VALUE   = 2'd0,
        S_MSG_ON  = 2'd1,
        S_MSG_OFF = 2'd2
    } state_t;

    // Four glyphs for one bank, d3 drives HEX3.
    typedef struct packed {
        glyph_t d3;
        glyph_t d2;
        glyph_t d1;
        glyph_t d0;
    } glyph4_t;

    // Text shown for each message id.
    function automatic glyph4_t msg_glyphs(input logic [1:0] id);
        glyph4_t g;
        g = {G_BLANK, G_BLANK, G_BLANK, G_BLANK};
        case (id)
            MSG_EASY: g = {G_E, G_A, G_S, G_Y};
            MSG_HARD: g = {G_H, G_A, G_R, G_D};
            MSG_DEAD: g = {G_D, G_E, G_A, G_D};
            default:  g = {G_BLANK, G_BLANK, G_BLANK, G_BLANK};
        endcase
        return g;
    endfunction

endpackage

// File: rtl/glyph_to_seg.sv
// Combinational glyph decoder: active-low segments {g,f,e,d,c,b,a}.
module glyph_to_seg
    import hex_disp_pkg::*;
(
    input  logic [GLYPH_W-1:0] glyph,
    output logic [SEG_W-1:0]   seg_c
);

    // Glyph code to segment pattern; anything unrecognised is dark.
    always_comb begin
        seg_c = SEG_BLANK;
        case (glyph)
            G_0:     seg_c = 7'b1000000;
            G_1:     seg_c = 7'b1111001;
            G_2:     seg_c = 7'b0100100;
            G_3:     seg_c = 7'b0110000;
            G_4:     seg_c = 7'b0011001;
            G_5:     seg_c = 7'b0010010;
            G_6:     seg_c = 7'b0000010;
            G_7:     seg_c = 7'b1111000;
            G_8:     seg_c = 7'b0000000;
            G_9:     seg_c = 7'b0010000;
            G_E:     seg_c = 7'b0000110;
            G_A:     seg_c = 7'b0001000;
            G_S:     seg_c = 7'b0010010;
            G_Y:     seg_c = 7'b0010001;
            G_H:     seg_c = 7'b0001001;
            G_R:     seg_c = 7'b0101111;
            G_D:     seg_c = 7'b0100001;
            default: seg_c = SEG_BLANK;
        endcase
    end

endmodule

// File: rtl/hex_msg_scheduler.sv
// Arbitrates the four-digit HEX bank between a BCD value and blinking text messages.
module hex_msg_scheduler
    import hex_disp_pkg::*;
#(
    parameter int unsigned TICK_CYCLES   = 50_000_000,
    parameter int unsigned MSG_ON_TICKS  = 2,
    parameter int unsigned MSG_OFF_TICKS = 1,
    parameter int unsigned MSG_BLINKS    = 3,
    parameter int unsigned LZ_BLANK      = 1
)(
    input  logic        clk,
    input  logic        rst_n,
    input  logic [15:0] value_bcd,
    input  logic        value_valid,
    input  logic        msg_req,
    input  logic [1:0]  msg_id,
    output logic        msg_ack,
    output logic        busy,
    output logic [6:0]  hex3,
    output logic [6:0]  hex2,
    output logic [6:0]  hex1,
    output logic [6:0]  hex0
);

    localparam int unsigned TICK_W    = (TICK_CYCLES > 1) ? $clog2(TICK_CYCLES) : 1;
    localparam int unsigned PHASE_MAX = (MSG_ON_TICKS > MSG_OFF_TICKS) ? MSG_ON_TICKS : MSG_OFF_TICKS;
    localparam int unsigned PHASE_W   = (PHASE_MAX > 1) ? $clog2(PHASE_MAX) : 1;
    localparam int unsigned BLINK_W   = $clog2(MSG_BLINKS + 1);

    state_t               state_q, state_d;
    logic [15:0]          value_q;
    logic [1:0]           id_q, id_d;
    logic [TICK_W-1:0]    tick_q, tick_d;
    logic [PHASE_W-1:0]   phase_q, phase_d;
    logic [BLINK_W-1:0]   blink_q, blink_d;
    logic                 ack_d, busy_d;
    logic                 tick_c;

    glyph_t [DIGITS-1:0]              sel_c;
    logic   [DIGITS-1:0][SEG_W-1:0]   seg_c;
    glyph4_t                          msg_g;
    logic                             lead;
    logic   [3:0]                     digit;

    assign tick_c = (tick_q == TICK_W'(TICK_CYCLES - 1));

    // Next-state, counters and handshake outputs.
    always_comb begin
        state_d = state_q;
        id_d    = id_q;
        phase_d = phase_q;
        blink_d = blink_q;
        tick_d  = tick_c ? '0 : tick_q + TICK_W'(1);
        ack_d   = 1'b0;
        busy_d  = busy;
        case (state_q)
            S_VALUE: begin
                if (msg_req) begin
                    state_d = S_MSG_ON;
                    id_d    = msg_id;
                    ack_d   = 1'b1;
                    busy_d  = 1'b1;
                    tick_d  = '0;
                    phase_d = '0;
                    blink_d = BLINK_W'(1);
                end
            end
            S_MSG_ON: begin
                if (tick_c) begin
                    if (phase_q == PHASE_W'(MSG_ON_TICKS - 1)) begin
                        phase_d = '0;
                        if (blink_q == BLINK_W'(MSG_BLINKS)) begin
                            state_d = S_VALUE;
                            busy_d  = 1'b0;
                        end else begin
                            state_d = S_MSG_OFF;
                        end
                    end else begin
                        phase_d = phase_q + PHASE_W'(1);
                    end
                end
            end
            S_MSG_OFF: begin
                if (tick_c) begin
                    if (phase_q == PHASE_W'(MSG_OFF_TICKS - 1)) begin
                        phase_d = '0;
                        blink_d = blink_q + BLINK_W'(1);
                        state_d = S_MSG_ON;
                    end else begin
                        phase_d = phase_q + PHASE_W'(1);
                    end
                end
            end
            default: begin
                state_d = S_VALUE;
                busy_d  = 1'b0;
            end
        endcase
    end

    // Glyph selection for the current state; leading zeros and non-BCD digits go dark.
    always_comb begin
        sel_c = {DIGITS{G_BLANK}};
        msg_g = msg_glyphs(id_q);
        lead  = (LZ_BLANK != 0);
        digit = '0;
        case (state_q)
            S_VALUE: begin
                for (int i = DIGITS - 1; i >= 0; i--) begin
                    digit = value_q[4*i +: 4];
                    if ((i != 0) && lead && (digit == 4'd0)) begin
                        sel_c[i] = G_BLANK;
                    end else begin
                        lead     = 1'b0;
                        sel_c[i] = (digit > 4'd9) ? G_BLANK : GLYPH_W'(digit);
                    end
                end
            end
            S_MSG_ON: sel_c = {msg_g.d3, msg_g.d2, msg_g.d1, msg_g.d0};
            default:  sel_c = {DIGITS{G_BLANK}};
        endcase
    end

    glyph_to_seg u_seg3 (.glyph(sel_c[3]), .seg_c(seg_c[3]));
    glyph_to_seg u_seg2 (.glyph(sel_c[2]), .seg_c(seg_c[2]));
    glyph_to_seg u_seg1 (.glyph(sel_c[1]), .seg_c(seg_c[1]));
    glyph_to_seg u_seg0 (.glyph(sel_c[0]), .seg_c(seg_c[0]));

    // State, counters, value latch and registered outputs.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= S_VALUE;
            value_q <= 16'h0000;
            id_q    <= MSG_EASY;
            tick_q  <= '0;
            phase_q <= '0;
            blink_q <= '0;
            msg_ack <= 1'b0;
            busy    <= 1'b0;
            hex3    <= SEG_BLANK;
            hex2    <= SEG_BLANK;
            hex1    <= SEG_BLANK;
            hex0    <= SEG_BLANK;
        end else begin
            state_q <= state_d;
            id_q    <= id_d;
            tick_q  <= tick_d;
            phase_q <= phase_d;
            blink_q <= blink_d;
            msg_ack <= ack_d;
            busy    <= busy_d;
            hex3    <= seg_c[3];
            hex2    <= seg_c[2];
            hex1    <= seg_c[1];
            hex0    <= seg_c[0];
            if (value_valid) begin
                value_q <= value_bcd;
            end
        end
    end

endmodule

// File: tb/tb_hex_msg_scheduler.sv
// Bench for hex_msg_scheduler: value table, hand-written message sequences, random traffic vs. timeline model.
module tb_hex_msg_scheduler;

    localparam int TICK    = 4;
    localparam int ON      = 2;
    localparam int OFF     = 1;
    localparam int BLINKS  = 2;
    localparam int SEQ_LEN = (BLINKS * ON + (BLINKS - 1) * OFF) * TICK;
    localparam int PERIOD  = (ON + OFF) * TICK;
    localparam int ON_LEN  = ON * TICK;

    localparam logic [6:0] BL = 7'h7F;
    localparam logic [6:0] S0 = 7'h40, S1 = 7'h79, S2 = 7'h24, S3 = 7'h30, S4 = 7'h19;
    localparam logic [6:0] S5 = 7'h12, S6 = 7'h02, S7 = 7'h78, S8 = 7'h00, S9 = 7'h10;
    localparam logic [27:0] BL4 = {BL, BL, BL, BL};

    logic        clk = 1'b0;
    logic        rst_n;
    logic [15:0] value_bcd;
    logic        value_valid;
    logic        msg_req;
    logic [1:0]  msg_id;
    logic        msg_ack;
    logic        busy;
    logic [6:0]  hex3, hex2, hex1, hex0;
    logic [27:0] hexes;

    int tests  = 0;
    int failed = 0;

    assign hexes = {hex3, hex2, hex1, hex0};

    always #5 clk = ~clk;

    hex_msg_scheduler #(
        .TICK_CYCLES  (TICK),
        .MSG_ON_TICKS (ON),
        .MSG_OFF_TICKS(OFF),
        .MSG_BLINKS   (BLINKS),
        .LZ_BLANK     (1)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .value_bcd  (value_bcd),
        .value_valid(value_valid),
        .msg_req    (msg_req),
        .msg_id     (msg_id),
        .msg_ack    (msg_ack),
        .busy       (busy),
        .hex3       (hex3),
        .hex2       (hex2),
        .hex1       (hex1),
        .hex0       (hex0)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            failed++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [6:0] digit_seg(input logic [3:0] d);
        case (d)
            4'd0: return S0;  4'd1: return S1;  4'd2: return S2;  4'd3: return S3;
            4'd4: return S4;  4'd5: return S5;  4'd6: return S6;  4'd7: return S7;
            4'd8: return S8;  4'd9: return S9;
            default: return BL;
        endcase
    endfunction

    function automatic logic [6:0] char_seg(input byte c);
        case (c)
            "E": return 7'h06;
            "A": return 7'h08;
            "S": return 7'h12;
            "Y": return 7'h11;
            "H": return 7'h09;
            "R": return 7'h2F;
            "D": return 7'h21;
            default: return BL;
        endcase
    endfunction

    function automatic logic [27:0] msg_segs(input logic [1:0] id);
        case (id)
            2'd0: return {char_seg("E"), char_seg("A"), char_seg("S"), char_seg("Y")};
            2'd1: return {char_seg("H"), char_seg("A"), char_seg("R"), char_seg("D")};
            2'd2: return {char_seg("D"), char_seg("E"), char_seg("A"), char_seg("D")};
            default: return BL4;
        endcase
    endfunction

    // Digits above the most significant non-zero digit are dark (HEX0 always shown).
    function automatic logic [27:0] value_segs(input logic [15:0] v);
        logic [27:0] r;
        int top;
        top = 0;
        for (int i = 0; i < 4; i++) if (v[4*i +: 4] != 4'd0) top = i;
        for (int i = 0; i < 4; i++) r[7*i +: 7] = (i > top) ? BL : digit_seg(v[4*i +: 4]);
        return r;
    endfunction

    // What the bank shows at a given age (cycles since acceptance, 0 = idle).
    function automatic logic [27:0] disp(input int age, input logic [1:0] id, input logic [15:0] v);
        if (age == 0) return value_segs(v);
        if (((age - 1) % PERIOD) < ON_LEN) return msg_segs(id);
        return BL4;
    endfunction

    int          m_age  = 0;
    logic [1:0]  m_id   = 2'd0;
    logic [15:0] m_val  = 16'h0;
    bit          m_init = 1'b0;
    logic [27:0] e_hex;
    logic        e_ack, e_busy;

    // Timeline reference model, compared every cycle just after the edge.
    always @(posedge clk) begin
        if (!rst_n) begin
            m_init = 1'b1;
            m_age  = 0;
            m_val  = 16'h0;
            e_hex  = BL4;
            e_ack  = 1'b0;
            e_busy = 1'b0;
        end else begin
            e_hex = disp(m_age, m_id, m_val);
            e_ack = 1'b0;
            if (m_age == 0) begin
                if (msg_req) begin
                    m_age = 1;
                    m_id  = msg_id;
                    e_ack = 1'b1;
                end
            end else if (m_age == SEQ_LEN) begin
                m_age = 0;
            end else begin
                m_age++;
            end
            e_busy = (m_age != 0);
            if (value_valid) m_val = value_bcd;
        end
        #1;
        if (m_init) check("model", {msg_ack, busy, hexes}, {e_ack, e_busy, e_hex});
    end

    typedef struct {
        logic [15:0] v;
        logic [27:0] exp;
    } vec_t;

    vec_t vecs[8];
    localparam logic [27:0] VAL_LAST = {S3, S0, S5, S6};
    localparam logic [27:0] HARD_S   = {7'h09, 7'h08, 7'h2F, 7'h21};
    localparam logic [27:0] EASY_S   = {7'h06, 7'h08, 7'h12, 7'h11};
    localparam logic [27:0] DEAD_S   = {7'h21, 7'h06, 7'h08, 7'h21};

    initial begin
        int acks, busys, hards, blanks, early_acks, n;
        rst_n = 1'b0; value_bcd = 16'h0; value_valid = 1'b0; msg_req = 1'b0; msg_id = 2'd0;

        vecs[0] = '{16'h0407, {BL, S4, S0, S7}};
        vecs[1] = '{16'h12F9, {S1, S2, BL, S9}};
        vecs[2] = '{16'h0000, {BL, BL, BL, S0}};
        vecs[3] = '{16'h0099, {BL, BL, S9, S9}};
        vecs[4] = '{16'h8100, {S8, S1, S0, S0}};
        vecs[5] = '{16'h0009, {BL, BL, BL, S9}};
        vecs[6] = '{16'hFFFF, BL4};
        vecs[7] = '{16'h3056, VAL_LAST};

        // Reset held three cycles, then one cycle to show zero.
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("reset_hex", hexes, BL4);
        end
        rst_n = 1'b1;
        @(negedge clk);
        check("post_reset_hex", hexes, {BL, BL, BL, S0});
        check("post_reset_busy_ack", {busy, msg_ack}, 2'b00);

        // Value display table.
        foreach (vecs[i]) begin
            value_bcd = vecs[i].v; value_valid = 1'b1;
            @(negedge clk);
            value_valid = 1'b0;
            @(negedge clk);
            check($sformatf("value_%h", vecs[i].v), hexes, vecs[i].exp);
        end

        // Full HARD sequence.
        msg_id = 2'd1; msg_req = 1'b1;
        acks = 0; busys = 0; hards = 0; blanks = 0;
        for (int k = 1; k <= 24; k++) begin
            @(negedge clk);
            if (msg_ack) begin acks++; msg_req = 1'b0; end
            busys += int'(busy);
            if (hexes == HARD_S) hards++;
            if (hexes == BL4) blanks++;
            if (k == 1) check("hard_ack_first", msg_ack, 1'b1);
            if (k == 22) check("hard_value_back", hexes, VAL_LAST);
        end
        check("hard_ack_count", acks, 1);
        check("hard_busy_cycles", busys, SEQ_LEN);
        check("hard_lit_cycles", hards, 2 * ON_LEN);
        check("hard_dark_cycles", blanks, OFF * TICK);

        // Request while busy, id change mid-message, value write during dark phase.
        msg_id = 2'd1; msg_req = 1'b1;
        early_acks = 0;
        for (int k = 1; k <= 30; k++) begin
            @(negedge clk);
            if (k == 1) begin check("b2b_first_ack", msg_ack, 1'b1); msg_req = 1'b0; end
            if (k == 3) begin msg_req = 1'b1; msg_id = 2'd0; end
            if (k == 9) begin value_bcd = 16'h0099; value_valid = 1'b1; end
            if (k == 10) value_valid = 1'b0;
            if (k >= 2 && k <= 21) early_acks += int'(msg_ack);
            if (k == 11 || k == 12) check("off_stays_dark", hexes, BL4);
            if (k == 14) check("id_sampled_once", hexes, HARD_S);
            if (k == 21) check("busy_falls", busy, 1'b0);
            if (k == 22) begin
                check("held_req_acked", msg_ack, 1'b1);
                check("value_one_cycle", hexes, {BL, BL, S9, S9});
                msg_req = 1'b0;
            end
            if (k == 23) check("easy_shown", hexes, EASY_S);
        end
        check("no_ack_while_busy", early_acks, 0);
        n = 0;
        while (busy && n < 100) begin @(negedge clk); n++; end
        check("easy_done", busy, 1'b0);

        // Reset in the middle of a message.
        msg_id = 2'd2; msg_req = 1'b1;
        @(negedge clk);
        check("dead_ack", msg_ack, 1'b1);
        msg_req = 1'b0;
        repeat (2) @(negedge clk);
        check("dead_shown", hexes, DEAD_S);
        rst_n = 1'b0;
        @(negedge clk);
        check("midmsg_reset_hex", hexes, BL4);
        check("midmsg_reset_busy", {busy, msg_ack}, 2'b00);
        rst_n = 1'b1;
        @(negedge clk);
        check("midmsg_reset_zero", hexes, {BL, BL, BL, S0});

        // Random traffic against the model.
        for (int c = 0; c < 1500; c++) begin
            @(negedge clk);
            rst_n       = ($urandom_range(0, 299) != 0);
            value_valid = ($urandom_range(0, 7) == 0);
            value_bcd   = {4'($urandom_range(0, 11)), 4'($urandom_range(0, 11)),
                           4'($urandom_range(0, 11)), 4'($urandom_range(0, 11))};
            if (msg_ack) begin
                msg_req = 1'b0;
            end else if (!msg_req && $urandom_range(0, 29) == 0) begin
                msg_req = 1'b1;
                msg_id  = 2'($urandom_range(0, 3));
            end
            if (busy && $urandom_range(0, 9) == 0) msg_id = 2'($urandom_range(0, 3));
        end
        rst_n = 1'b1; msg_req = 1'b0; value_valid = 1'b0;
        repeat (30) @(negedge clk);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, %0d failed so far", failed);
        $fatal(1, "watchdog");
    end

endmodule
